// File: rtl/hdmi_video_timing.sv
// 640x480@60 raster generator for the HDMI path: issues framebuffer read coordinates,
// delays sync/DE to match the read latency and expands RGB332 pixels to 24-bit RGB.
module hdmi_video_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned READ_LAT = 2,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    input  logic [7:0] pixel_in,
    output logic [7:0] hdmi_r,
    output logic [7:0] hdmi_g,
    output logic [7:0] hdmi_b,
    output logic       hdmi_hsync,
    output logic       hdmi_vsync,
    output logic       hdmi_de,
    output logic       frame_start
);

    localparam int unsigned CW = 10;

    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic first;
    } flags_t;

    logic [CW-1:0]       h_cnt;
    logic [CW-1:0]       v_cnt;
    flags_t              flags_c;
    flags_t [READ_LAT:0] pipe;
    logic [23:0]         rgb_c;

    // Free-running raster counters; the line counter advances on the horizontal wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
        end else begin
            h_cnt <= h_cnt + CW'(1);
        end
    end

    always_comb begin
        flags_c        = '0;
        flags_c.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        flags_c.hsync  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        flags_c.vsync  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        flags_c.first  = (h_cnt == '0) && (v_cnt == '0);
    end

    // Stage 0 is aligned with pix_x/pix_y; stage READ_LAT is aligned with pixel_in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_x <= '0;
            pix_y <= '0;
            pipe  <= '0;
        end else begin
            pix_x <= flags_c.active ? h_cnt : '0;
            pix_y <= flags_c.active ? v_cnt : '0;
            pipe  <= {pipe[READ_LAT-1:0], flags_c};
        end
    end

    // RGB332 to RGB888 by bit replication; blanked outside the active area.
    always_comb begin
        rgb_c = '0;
        if (pipe[READ_LAT].active) begin
            rgb_c = {pixel_in[7:5], pixel_in[7:5], pixel_in[7:6],
                     pixel_in[4:2], pixel_in[4:2], pixel_in[4:3],
                     pixel_in[1:0], pixel_in[1:0], pixel_in[1:0], pixel_in[1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdmi_r      <= '0;
            hdmi_g      <= '0;
            hdmi_b      <= '0;
            hdmi_hsync  <= ~SYNC_POL;
            hdmi_vsync  <= ~SYNC_POL;
            hdmi_de     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            {hdmi_r, hdmi_g, hdmi_b} <= rgb_c;
            hdmi_hsync  <= pipe[READ_LAT].hsync ? SYNC_POL : ~SYNC_POL;
            hdmi_vsync  <= pipe[READ_LAT].vsync ? SYNC_POL : ~SYNC_POL;
            hdmi_de     <= pipe[READ_LAT].active;
            frame_start <= pipe[READ_LAT].first;
        end
    end

endmodule
